// File: rtl/c432_query_ctrl_if.sv
// Query/core/result bundle between the SAT-attack harness and c432_query_ctrl.
// The slave modport is the controller's side; the master modport is the harness side.
interface c432_query_ctrl_if #(
   parameter int PI_W  = 36,
   parameter int KEY_W = 6,
   parameter int PO_W  = 7
);
   logic             q_valid;
   logic             q_ready;
   logic [PI_W-1:0]  q_pi;
   logic [KEY_W-1:0] q_key;

   logic [PI_W-1:0]  core_pi;
   logic [KEY_W-1:0] core_key;
   logic [PO_W-1:0]  core_po;
   logic [PO_W-1:0]  orc_po;

   logic             r_valid;
   logic             r_ready;
   logic [PO_W-1:0]  r_po;
   logic [PO_W-1:0]  r_orc;
   logic             r_mismatch;

   modport slave (
      input  q_valid, q_pi, q_key, core_po, orc_po, r_ready,
      output q_ready, core_pi, core_key, r_valid, r_po, r_orc, r_mismatch
   );

   modport master (
      output q_valid, q_pi, q_key, core_po, orc_po, r_ready,
      input  q_ready, core_pi, core_key, r_valid, r_po, r_orc, r_mismatch
   );
endinterface

// File: rtl/c432_query_ctrl.sv
// Sequences one query at a time through the locked and oracle c432 cores:
// register inputs, wait a fixed settle time, capture both outputs, hand back.
module c432_query_ctrl #(
   parameter int PI_W   = 36,
   parameter int KEY_W  = 6,
   parameter int PO_W   = 7,
   parameter int SETTLE = 2,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cnt_clr,
   c432_query_ctrl_if.slave     bus,
   output logic                 busy,
   output logic [CNT_W-1:0]     q_count,
   output logic [CNT_W-1:0]     mm_count
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_RESP
   } state_t;

   localparam logic [7:0] SETTLE_INIT = 8'(SETTLE - 1);

   state_t            r_state;
   state_t            w_next_state;
   logic              w_accept;
   logic              w_capture;
   logic              w_handshake;

   logic [7:0]        r_settle_cnt;
   logic [PI_W-1:0]   r_core_pi;
   logic [KEY_W-1:0]  r_core_key;
   logic [PO_W-1:0]   r_cap_po;
   logic [PO_W-1:0]   r_cap_orc;
   logic              r_cap_mm;
   logic [CNT_W-1:0]  r_q_count;
   logic [CNT_W-1:0]  r_mm_count;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next_state;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_capture    = 1'b0;
      w_handshake  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.q_valid) begin
               w_accept     = 1'b1;
               w_next_state = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (r_settle_cnt == 8'd0) begin
               w_capture    = 1'b1;
               w_next_state = ST_RESP;
            end
         end
         ST_RESP: begin
            if (bus.r_ready) begin
               w_handshake  = 1'b1;
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Core inputs change only on acceptance, so the cores stay quiescent between queries.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_settle_cnt <= 8'd0;
         r_core_pi    <= '0;
         r_core_key   <= '0;
         r_cap_po     <= '0;
         r_cap_orc    <= '0;
         r_cap_mm     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_core_pi    <= bus.q_pi;
            r_core_key   <= bus.q_key;
            r_settle_cnt <= SETTLE_INIT;
         end else if (r_state == ST_SETTLE && r_settle_cnt != 8'd0) begin
            r_settle_cnt <= r_settle_cnt - 8'd1;
         end
         if (w_capture) begin
            r_cap_po  <= bus.core_po;
            r_cap_orc <= bus.orc_po;
            r_cap_mm  <= (bus.core_po != bus.orc_po);
         end
      end
   end

   // Saturating statistics; clear takes priority over a coincident increment.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         r_q_count  <= '0;
         r_mm_count <= '0;
      end else if (w_handshake) begin
         if (r_q_count != '1)
            r_q_count <= r_q_count + CNT_W'(1);
         if (r_cap_mm && r_mm_count != '1)
            r_mm_count <= r_mm_count + CNT_W'(1);
      end
   end

   assign bus.q_ready    = (r_state == ST_IDLE);
   assign bus.r_valid    = (r_state == ST_RESP);
   assign bus.core_pi    = r_core_pi;
   assign bus.core_key   = r_core_key;
   assign bus.r_po       = r_cap_po;
   assign bus.r_orc      = r_cap_orc;
   assign bus.r_mismatch = r_cap_mm;
   assign busy           = (r_state != ST_IDLE);
   assign q_count        = r_q_count;
   assign mm_count       = r_mm_count;

endmodule

// File: tb/tb_c432_query_ctrl.sv
// Self-checking bench for c432_query_ctrl: directed cases plus randomized queries
// against a behavioural locked/oracle core pair and saturating counter model.
module tb_c432_query_ctrl;

   localparam int         PI_W   = 36;
   localparam int         KEY_W  = 6;
   localparam int         PO_W   = 7;
   localparam int         SETTLE = 2;
   localparam int         CNT_W  = 4;
   localparam int         CNT_MAX = (1 << CNT_W) - 1;
   localparam logic [5:0] KEY_OK = 6'h2A;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cnt_clr = 1'b0;
   logic             busy;
   logic [CNT_W-1:0] q_count;
   logic [CNT_W-1:0] mm_count;

   int n_checks = 0;
   int n_errors = 0;
   int model_q  = 0;
   int model_mm = 0;

   bit        use_model = 1'b0;
   logic [6:0] fix_core = 7'h00;
   logic [6:0] fix_orc  = 7'h00;

   c432_query_ctrl_if #(.PI_W(PI_W), .KEY_W(KEY_W), .PO_W(PO_W)) bus ();

   c432_query_ctrl #(
      .PI_W(PI_W), .KEY_W(KEY_W), .PO_W(PO_W), .SETTLE(SETTLE), .CNT_W(CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cnt_clr  (cnt_clr),
      .bus      (bus),
      .busy     (busy),
      .q_count  (q_count),
      .mm_count (mm_count)
   );

   always #5 clk = ~clk;

   // Stand-in locked core: output is a fold of the pattern, perturbed by any wrong key bit.
   function automatic logic [6:0] lock_fn(input logic [35:0] pi, input logic [5:0] key);
      logic [6:0] fold;
      fold = pi[6:0] ^ pi[13:7] ^ pi[20:14] ^ pi[27:21] ^ pi[34:28] ^ {6'b0, pi[35]};
      return fold ^ {1'b0, key ^ KEY_OK};
   endfunction

   function automatic logic [35:0] rand_pi();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[35:0];
   endfunction

   always_comb bus.core_po = use_model ? lock_fn(bus.core_pi, bus.core_key) : fix_core;
   always_comb bus.orc_po  = use_model ? lock_fn(bus.core_pi, KEY_OK) : fix_orc;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v >= CNT_MAX) ? CNT_MAX : v + 1;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_q_ready"},  bus.q_ready, 1'b1);
      check({tag, "_r_valid"},  bus.r_valid, 1'b0);
      check({tag, "_busy"},     busy, 1'b0);
      check({tag, "_core_pi"},  bus.core_pi, 36'h0);
      check({tag, "_core_key"}, bus.core_key, 6'h0);
      check({tag, "_r_po"},     bus.r_po, 7'h0);
      check({tag, "_r_mm"},     bus.r_mismatch, 1'b0);
      check({tag, "_q_count"},  q_count, 4'h0);
      check({tag, "_mm_count"}, mm_count, 4'h0);
   endtask

   // Reset held for several cycles while a query is offered; nothing may be accepted.
   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst = 1'b1;
      bus.q_valid = 1'b1;
      bus.q_pi  = rand_pi();
      bus.q_key = 6'($urandom());
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         check_reset_outputs("reset");
      end
      rst = 1'b0;
      bus.q_valid = 1'b0;
      model_q  = 0;
      model_mm = 0;
   endtask

   task automatic run_query(input logic [35:0] pi, input logic [5:0] key, input int stall,
                            input logic [6:0] exp_po, input logic [6:0] exp_orc,
                            input bit late_chg, input bit clr_on_hs);
      int   lat;
      logic exp_mm;
      exp_mm = (exp_po != exp_orc);
      @(negedge clk);
      check("idle_q_ready", bus.q_ready, 1'b1);
      bus.q_valid = 1'b1;
      bus.q_pi    = pi;
      bus.q_key   = key;
      @(negedge clk);
      bus.q_valid = 1'b0;
      bus.q_pi    = rand_pi();
      bus.q_key   = 6'($urandom());
      check("core_pi",      bus.core_pi, pi);
      check("core_key",     bus.core_key, key);
      check("settle_busy",  busy, 1'b1);
      check("settle_ready", bus.q_ready, 1'b0);
      lat = 1;
      while (!bus.r_valid && lat <= 20) begin
         @(negedge clk);
         lat++;
      end
      if (!bus.r_valid) begin
         check("r_valid_timeout", 1'b0, 1'b1);
         return;
      end
      check("latency", lat, SETTLE + 1);
      if (late_chg) fix_core = 7'h7F;
      check("r_po",       bus.r_po, exp_po);
      check("r_orc",      bus.r_orc, exp_orc);
      check("r_mismatch", bus.r_mismatch, exp_mm);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check("stall_r_valid", bus.r_valid, 1'b1);
         check("stall_r_po",    bus.r_po, exp_po);
         check("stall_r_orc",   bus.r_orc, exp_orc);
         check("stall_r_mm",    bus.r_mismatch, exp_mm);
         check("stall_q_ready", bus.q_ready, 1'b0);
      end
      bus.r_ready = 1'b1;
      cnt_clr     = clr_on_hs;
      @(negedge clk);
      bus.r_ready = 1'b0;
      cnt_clr     = 1'b0;
      if (clr_on_hs) begin
         model_q  = 0;
         model_mm = 0;
      end else begin
         model_q = sat_inc(model_q);
         if (exp_mm) model_mm = sat_inc(model_mm);
      end
      check("post_r_valid",  bus.r_valid, 1'b0);
      check("post_q_ready",  bus.q_ready, 1'b1);
      check("post_busy",     busy, 1'b0);
      check("q_count",       q_count, model_q);
      check("mm_count",      mm_count, model_mm);
      check("core_pi_hold",  bus.core_pi, pi);
      check("core_key_hold", bus.core_key, key);
   endtask

   task automatic mid_reset(input bit in_resp);
      int lat;
      @(negedge clk);
      bus.q_valid = 1'b1;
      bus.q_pi    = rand_pi();
      bus.q_key   = 6'($urandom());
      @(negedge clk);
      bus.q_valid = 1'b0;
      check("mid_busy", busy, 1'b1);
      if (in_resp) begin
         lat = 0;
         while (!bus.r_valid && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         check("mid_resp_reached", bus.r_valid, 1'b1);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_q  = 0;
      model_mm = 0;
      check_reset_outputs(in_resp ? "rst_resp" : "rst_settle");
   endtask

   initial begin
      logic [35:0] pi;
      logic [5:0]  key;
      bus.q_valid = 1'b0;
      bus.q_pi    = '0;
      bus.q_key   = '0;
      bus.r_ready = 1'b0;

      do_reset(2);
      @(negedge clk);
      check("no_accept_busy", busy, 1'b0);

      // Matching query with r_ready high on arrival.
      fix_core = 7'h55; fix_orc = 7'h55;
      run_query(36'h0_0000_0001, 6'h3F, 0, 7'h55, 7'h55, 1'b0, 1'b0);

      // Mismatch held under 5 cycles of backpressure.
      fix_core = 7'h55; fix_orc = 7'h54;
      run_query(rand_pi(), 6'h00, 5, 7'h55, 7'h54, 1'b0, 1'b0);

      // core_po moves right after capture; captured value must not follow it.
      fix_core = 7'h00; fix_orc = 7'h00;
      run_query(rand_pi(), 6'h15, 2, 7'h00, 7'h00, 1'b1, 1'b0);

      // Randomized queries through the behavioural core pair; counters saturate on the way.
      use_model = 1'b1;
      for (int n = 0; n < 24; n++) begin
         pi  = rand_pi();
         key = ($urandom_range(0, 1) == 1) ? KEY_OK : 6'($urandom());
         run_query(pi, key, $urandom_range(0, 3), lock_fn(pi, key), lock_fn(pi, KEY_OK),
                   1'b0, 1'b0);
      end
      check("sat_q_count", q_count, 4'hF);

      // Clear coincident with a handshake wins over the increment.
      pi = rand_pi();
      run_query(pi, 6'h01, 1, lock_fn(pi, 6'h01), lock_fn(pi, KEY_OK), 1'b0, 1'b1);
      check("clr_q_count_zero", q_count, 4'h0);

      pi = rand_pi();
      run_query(pi, 6'h07, 0, lock_fn(pi, 6'h07), lock_fn(pi, KEY_OK), 1'b0, 1'b0);

      // Clear while idle.
      @(negedge clk);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      model_q = 0; model_mm = 0;
      check("idle_clr_q", q_count, 4'h0);
      check("idle_clr_mm", mm_count, 4'h0);
      check("idle_clr_busy", busy, 1'b0);

      mid_reset(1'b0);
      pi = rand_pi();
      run_query(pi, KEY_OK, 1, lock_fn(pi, KEY_OK), lock_fn(pi, KEY_OK), 1'b0, 1'b0);
      mid_reset(1'b1);
      pi = rand_pi();
      run_query(pi, 6'h3C, 0, lock_fn(pi, 6'h3C), lock_fn(pi, KEY_OK), 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/c432_query_ctrl.md
# c432_query_ctrl

Sequencing controller for the key-locked c432 core in the SAT-attack test harness. Accepts queries (one 36-bit input pattern plus one 6-bit candidate key) over a valid/ready handshake. Drives the locked core and the oracle core (c432 with the correct key hard-wired) from registered inputs, waits a fixed settle interval, then captures both 7-bit output vectors. Returns them with a mismatch flag and keeps query and mismatch statistics.

## Interface
- PI_W, 36, primary-input width (N1..N115 in declaration order, bit 0 = N1)
- KEY_W, 6, key width (bit 0 = keybit1)
- PO_W, 7, primary-output width (bit 0 = N223 … bit 6 = N432)
- SETTLE, 2, combinational settle cycles; legal range 1..255
- CNT_W, 16, statistics counter width

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- q_valid  in  1  query offered
- q_ready  out  1  controller can accept a query
- q_pi  in  PI_W  query input pattern
- q_key  in  KEY_W  query candidate key
- core_pi  out  PI_W  registered pattern to locked and oracle cores
- core_key  out  KEY_W  registered key to locked core
- core_po  in  PO_W  locked-core outputs
- orc_po  in  PO_W  oracle-core outputs
- r_valid  out  1  result available
- r_ready  in  1  result consumed
- r_po  out  PO_W  captured locked-core outputs
- r_orc  out  PO_W  captured oracle outputs
- r_mismatch  out  1  r_po != r_orc
- busy  out  1  FSM not in IDLE
- cnt_clr  in  1  clear both counters
- q_count  out  CNT_W  completed queries (response handshakes)
- mm_count  out  CNT_W  completed queries with r_mismatch=1

## Operation
- FSM states: IDLE, SETTLE, RESP.
- IDLE: q_ready=1. On q_valid&&q_ready:
  - load core_pi←q_pi and core_key←q_key.
  - load settle counter←SETTLE-1.
  - go to SETTLE.
- SETTLE: q_ready=0, core_pi/core_key held.
  - If counter≠0: decrement.
  - If counter=0: capture r_po←core_po, r_orc←orc_po, r_mismatch←(core_po≠orc_po). Go to RESP.
- RESP: r_valid=1; r_po/r_orc/r_mismatch held stable.
  - On r_valid&&r_ready: increment q_count; increment mm_count if r_mismatch; go to IDLE.
  - Otherwise stay in RESP indefinitely.
- core_pi/core_key keep the last query's values after return to IDLE, so the cores stay quiescent; they change only on acceptance.
- q_pi/q_key are ignored outside the acceptance cycle.
- Counters saturate at all-ones and never wrap.
- cnt_clr zeroes both counters next cycle. When cnt_clr coincides with an increment, clear wins (result 0). cnt_clr does not affect the FSM.
- busy = (state≠IDLE).
- Reset values:
  - state=IDLE, q_ready=1, r_valid=0, busy=0.
  - core_pi=0, core_key=0, r_po=0, r_orc=0, r_mismatch=0.
  - q_count=0, mm_count=0.
- Reset mid-query (SETTLE or RESP): the in-flight query is discarded, nothing is counted, and all outputs return to their reset values on the next edge.

## Timing
- Query accepted at edge of cycle T.
- core_pi/core_key valid from cycle T+1.
- SETTLE occupies cycles T+1..T+SETTLE; capture happens at the end of cycle T+SETTLE.
- r_valid=1 from cycle T+SETTLE+1.
- Handshake at the end of cycle R:
  - counters updated in cycle R+1.
  - q_ready=1 in cycle R+1.
- No back-to-back acceptance: minimum query period is SETTLE+2 cycles, with r_ready tied high.
- q_ready is a pure function of state; it does not depend on q_valid (no combinational path q_valid→q_ready).
- r_valid never drops before its handshake except on rst.

## Test plan
- Reset: hold rst 2 cycles with a query valid. Required: q_ready=1, r_valid=0, core_pi=0, core_key=0, counters=0, and no acceptance occurs.
- Matching query: SETTLE=2, q_pi=36'h0_0000_0001, q_key=6'h3F, bench drives core_po=orc_po=7'h55, r_ready=1. Required:
  - accept at T; r_valid at T+3 with r_po=r_orc=7'h55 and r_mismatch=0.
  - q_count=1, mm_count=0 at T+4; q_ready=1 at T+4.
- Mismatch plus backpressure: q_key=6'h00, core_po=7'h55, orc_po=7'h54, r_ready low for 5 cycles. Required:
  - r_valid held 6 cycles; r_po=7'h55, r_orc=7'h54, r_mismatch=1 stable throughout.
  - q_ready=0 throughout; after handshake mm_count=1.
- Capture instant: core_po changes from 7'h00 to 7'h7F in cycle T+SETTLE+1. Required: r_po=7'h00 (captured at end of T+SETTLE).
- Saturation and clear: CNT_W=4, run 17 queries. Required: q_count=4'hF. Then cnt_clr coincident with a handshake. Required: q_count=0.
- Reset mid-query: assert rst in the SETTLE cycle, then in the RESP cycle. Required: next cycle IDLE, r_valid=0, q_count unchanged at 0, and the next query completes normally.
